// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding RV32I access between a pipeline request/response
// handshake and a word-wide memory port. It handles byte lanes, sign extension and bus timeout.
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_ack,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        is_store_r, is_store_s;
  logic [2:0]  funct3_r, funct3_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic        req_ready_r, req_ready_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic        rsp_error_r, rsp_error_s;
  logic [31:0] rsp_rdata_r, rsp_rdata_s;
  logic        mem_read_r, mem_read_s;
  logic        mem_write_r, mem_write_s;
  logic [31:0] mem_address_r, mem_address_s;
  logic [31:0] mem_write_data_r, mem_write_data_s;
  logic [3:0]  mem_byte_en_r, mem_byte_en_s;

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    logic ok;
    if (st) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = 4'b0011 << a;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic st, input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    if (!st) begin
      d = 32'd0;
    end else begin
      case (f3[1:0])
        2'b00:   d = {4{wd[7:0]}};
        2'b01:   d = {2{wd[15:0]}};
        default: d = wd;
      endcase
    end
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then size and extend it.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b100:  r = {24'd0, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b101:  r = {16'd0, s[15:0]};
      3'b010:  r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s          = state_r;
    cnt_s            = cnt_r;
    is_store_s       = is_store_r;
    funct3_s         = funct3_r;
    addr_s           = addr_r;
    wdata_s          = wdata_r;
    req_ready_s      = req_ready_r;
    rsp_valid_s      = rsp_valid_r;
    rsp_error_s      = rsp_error_r;
    rsp_rdata_s      = rsp_rdata_r;
    mem_read_s       = mem_read_r;
    mem_write_s      = mem_write_r;
    mem_address_s    = mem_address_r;
    mem_write_data_s = mem_write_data_r;
    mem_byte_en_s    = mem_byte_en_r;
    case (state_r)
      IDLE: begin
        if (req_ready_r && req_valid) begin
          is_store_s  = req_is_store;
          funct3_s    = req_funct3;
          addr_s      = req_addr;
          wdata_s     = req_wdata;
          req_ready_s = 1'b0;
          if (is_legal(req_is_store, req_funct3) && !is_misaligned(req_funct3, req_addr[1:0])) begin
            state_s          = ACCESS;
            cnt_s            = 8'd0;
            mem_read_s       = !req_is_store;
            mem_write_s      = req_is_store;
            mem_address_s    = {req_addr[31:2], 2'b00};
            mem_byte_en_s    = byte_mask(req_funct3, req_addr[1:0]);
            mem_write_data_s = lane_data(req_is_store, req_funct3, req_wdata);
          end else begin
            state_s     = RESP;
            rsp_valid_s = 1'b1;
            rsp_error_s = 1'b1;
            rsp_rdata_s = 32'd0;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_s          = RESP;
          mem_read_s       = 1'b0;
          mem_write_s      = 1'b0;
          mem_address_s    = 32'd0;
          mem_byte_en_s    = 4'd0;
          mem_write_data_s = 32'd0;
          rsp_valid_s      = 1'b1;
          rsp_error_s      = 1'b0;
          rsp_rdata_s      = is_store_r ? 32'd0 : load_format(funct3_r, addr_r[1:0], mem_read_data);
        end else if (cnt_r == TIMEOUT_LAST) begin
          // Ack loses only when absent: an ack on the last allowed cycle still completes.
          cnt_s            = cnt_r + 8'd1;
          state_s          = RESP;
          mem_read_s       = 1'b0;
          mem_write_s      = 1'b0;
          mem_address_s    = 32'd0;
          mem_byte_en_s    = 4'd0;
          mem_write_data_s = 32'd0;
          rsp_valid_s      = 1'b1;
          rsp_error_s      = 1'b1;
          rsp_rdata_s      = 32'd0;
        end else begin
          cnt_s            = cnt_r + 8'd1;
          mem_read_s       = !is_store_r;
          mem_write_s      = is_store_r;
          mem_address_s    = {addr_r[31:2], 2'b00};
          mem_byte_en_s    = byte_mask(funct3_r, addr_r[1:0]);
          mem_write_data_s = lane_data(is_store_r, funct3_r, wdata_r);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s     = IDLE;
          rsp_valid_s = 1'b0;
          rsp_error_s = 1'b0;
          rsp_rdata_s = 32'd0;
          req_ready_s = 1'b1;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s          = IDLE;
        cnt_s            = 8'd0;
        req_ready_s      = 1'b0;
        rsp_valid_s      = 1'b0;
        rsp_error_s      = 1'b0;
        rsp_rdata_s      = 32'd0;
        mem_read_s       = 1'b0;
        mem_write_s      = 1'b0;
        mem_address_s    = 32'd0;
        mem_byte_en_s    = 4'd0;
        mem_write_data_s = 32'd0;
      end
    endcase
  end

  // State, captured request and output registers; reset forces IDLE with all outputs low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      cnt_r            <= 8'd0;
      is_store_r       <= 1'b0;
      funct3_r         <= 3'd0;
      addr_r           <= 32'd0;
      wdata_r          <= 32'd0;
      req_ready_r      <= 1'b0;
      rsp_valid_r      <= 1'b0;
      rsp_error_r      <= 1'b0;
      rsp_rdata_r      <= 32'd0;
      mem_read_r       <= 1'b0;
      mem_write_r      <= 1'b0;
      mem_address_r    <= 32'd0;
      mem_write_data_r <= 32'd0;
      mem_byte_en_r    <= 4'd0;
    end else begin
      state_r          <= state_s;
      cnt_r            <= cnt_s;
      is_store_r       <= is_store_s;
      funct3_r         <= funct3_s;
      addr_r           <= addr_s;
      wdata_r          <= wdata_s;
      req_ready_r      <= req_ready_s;
      rsp_valid_r      <= rsp_valid_s;
      rsp_error_r      <= rsp_error_s;
      rsp_rdata_r      <= rsp_rdata_s;
      mem_read_r       <= mem_read_s;
      mem_write_r      <= mem_write_s;
      mem_address_r    <= mem_address_s;
      mem_write_data_r <= mem_write_data_s;
      mem_byte_en_r    <= mem_byte_en_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_error      = rsp_error_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign mem_read       = mem_read_r;
  assign mem_write      = mem_write_r;
  assign mem_address    = mem_address_r;
  assign mem_write_data = mem_write_data_r;
  assign mem_byte_en    = mem_byte_en_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a word-level memory model predicts
// every memory transaction and every response; responder and monitor check them independently.
module tb_load_store_unit;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write, mem_ack;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_byte_en;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en),
    .mem_ack(mem_ack), .mem_read_data(mem_read_data)
  );

  typedef struct {
    bit        is_store;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    int        delay;
    bit [31:0] rdword;
  } op_t;

  op_t       op_q[$];
  bit [31:0] exp_rdata_q[$];
  bit        exp_err_q[$];
  bit [31:0] mem_words[int unsigned];
  int        n_cmp = 0;
  int        n_fail = 0;
  int        hold_cnt = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] word_at(input int unsigned wi);
    if (mem_words.exists(wi)) return mem_words[wi];
    return (wi * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Reference model: predict the memory transaction and response, then drive the request.
  task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input int delay);
    bit legal;
    int nb, k, guard;
    bit [31:0] w, v;
    op_t op;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 400 cycles");
      return;
    end
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb = 1 << f3[1:0];
    k = int'(a[1:0]);
    if (!legal || (a % nb) != 0) begin
      exp_rdata_q.push_back(32'd0);
      exp_err_q.push_back(1'b1);
    end else begin
      w = word_at(a >> 2);
      op.is_store = st;
      op.addr = {a[31:2], 2'b00};
      op.delay = delay;
      op.rdword = w;
      op.be = 4'd0;
      op.wdata = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (i >= k && i < k + nb) op.be[i] = 1'b1;
        op.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
      if (delay >= TO) begin
        exp_rdata_q.push_back(32'd0);
        exp_err_q.push_back(1'b1);
      end else if (st) begin
        for (int i = 0; i < 4; i++) if (op.be[i]) w[8*i +: 8] = op.wdata[8*i +: 8];
        mem_words[a >> 2] = w;
        exp_rdata_q.push_back(32'd0);
        exp_err_q.push_back(1'b0);
      end else begin
        v = w >> (8 * k);
        if (nb == 1) begin
          v = v & 32'hFF;
          if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (nb == 2) begin
          v = v & 32'hFFFF;
          if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end
        exp_rdata_q.push_back(v);
        exp_err_q.push_back(1'b0);
      end
      op_q.push_back(op);
    end
    req_valid = 1'b1;
    req_is_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_rdata_q.size() != 0 || op_q.size() != 0 || !req_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d responses outstanding expected 0", exp_rdata_q.size());
    end
  endtask

  // Memory responder: checks each strobe against the predicted transaction and acks on schedule.
  initial begin
    bit busy = 0;
    int cyc = 0;
    op_t cur;
    mem_ack = 1'b0;
    mem_read_data = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0;
        mem_ack = 1'b0;
      end else if (mem_read || mem_write) begin
        if (!busy) begin
          if (op_q.size() == 0) begin
            check32("unexpected_strobe", {30'd0, mem_read, mem_write}, 32'd0);
            cur.is_store = mem_write;
            cur.addr = mem_address;
            cur.be = mem_byte_en;
            cur.wdata = mem_write_data;
            cur.delay = 0;
            cur.rdword = 32'd0;
          end else begin
            cur = op_q.pop_front();
          end
          busy = 1;
          cyc = 0;
        end
        check32("mem_write", mem_write, cur.is_store);
        check32("mem_read", mem_read, !cur.is_store);
        check32("mem_address", mem_address, cur.addr);
        check32("mem_byte_en", mem_byte_en, cur.be);
        if (cur.is_store) check32("mem_write_data", mem_write_data, cur.wdata);
        cyc++;
        if (cyc == cur.delay + 1) begin
          mem_ack = 1'b1;
          mem_read_data = cur.is_store ? $urandom : cur.rdword;
        end else begin
          mem_ack = 1'b0;
          mem_read_data = $urandom;
        end
      end else begin
        if (busy) begin
          check32("strobe_cycles", cyc, (cur.delay >= TO) ? TO : cur.delay + 1);
          busy = 0;
        end
        mem_ack = 1'b0;
        mem_read_data = $urandom;
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake and checks hold behaviour.
  initial begin
    bit prev_held = 0;
    bit [31:0] prev_rdata = 32'd0;
    bit prev_err = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_held = 0;
      end else begin
        if (prev_held) check32("rsp_valid_held", rsp_valid, 1'b1);
        if (rsp_valid) begin
          check32("req_ready_in_resp", req_ready, 1'b0);
          check32("strobes_in_resp", {30'd0, mem_read, mem_write}, 32'd0);
          if (prev_held) begin
            check32("rsp_rdata_stable", rsp_rdata, prev_rdata);
            check32("rsp_error_stable", rsp_error, prev_err);
          end
          if (rsp_ready) begin
            if (exp_rdata_q.size() == 0) begin
              check32("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
              check32("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
              check32("rsp_error", rsp_error, exp_err_q.pop_front());
            end
          end
          prev_held = !rsp_ready;
          prev_rdata = rsp_rdata;
          prev_err = rsp_error;
        end else begin
          prev_held = 0;
        end
      end
    end
  end

  // Response back-pressure: random unless a hold window is requested.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        rsp_ready = 1'b0;
        hold_cnt--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int r, dly;
    reset = 1'b1;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check32("reset_req_ready", req_ready, 1'b0);
    check32("reset_rsp_valid", rsp_valid, 1'b0);
    check32("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check32("reset_rsp_rdata", rsp_rdata, 32'd0);
    check32("reset_mem_address", mem_address, 32'd0);
    reset = 1'b0;
    #1;
    check32("release_req_ready_low", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check32("release_req_ready_high", req_ready, 1'b1);

    issue(1'b1, 3'b000, 32'h103, 32'hAB, 1);
    mem_words[32'h80] = 32'h0080_0000;
    issue(1'b0, 3'b000, 32'h202, 32'd0, 0);
    issue(1'b0, 3'b100, 32'h202, 32'd0, 2);

    wait_idle();
    issue(1'b0, 3'b001, 32'h201, 32'd0, 0);
    check32("err_latency_lh", rsp_valid, 1'b1);
    wait_idle();
    issue(1'b1, 3'b010, 32'h302, 32'h1234_5678, 0);
    check32("err_latency_sw", rsp_valid, 1'b1);

    issue(1'b0, 3'b010, 32'h40, 32'd0, TO + 5);
    issue(1'b0, 3'b010, 32'h44, 32'd0, TO - 1);

    wait_idle();
    hold_cnt = 12;
    issue(1'b0, 3'b010, 32'h48, 32'd0, 0);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check32("hold_rsp_valid", rsp_valid, 1'b1);
      check32("hold_req_ready", req_ready, 1'b0);
    end

    wait_idle();
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1000);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check32("async_mem_write", mem_write, 1'b0);
    check32("async_req_ready", req_ready, 1'b0);
    check32("async_rsp_valid", rsp_valid, 1'b0);
    exp_rdata_q.delete();
    exp_err_q.delete();
    op_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check32("rerelease_req_ready_low", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check32("rerelease_req_ready_high", req_ready, 1'b1);
    issue(1'b0, 3'b010, 32'h0, 32'd0, 0);
    @(posedge clk);
    #1;
    check32("min_latency_rsp_valid", rsp_valid, 1'b1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) dly = TO + 3;
      else if (r == 1) dly = TO - 1;
      else dly = $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 1023)), $urandom, dly);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
